delay_output_monitor: RTL
=========================

Name: delay_output_monitor

Overview:
- Sequential monitor placed directly downstream of the gate-level delay module. Consumes its combinational output o_d.
- Synchronises the signal into the i_clk domain and filters out hazard glitches produced by unequal gate delays.
- Reports clean edges, edge counts, glitch counts and high-pulse widths, so delay/hazard behaviour can be checked cycle-accurately in benches and on board.

Parameters:
FILTER_LEN, 3, consecutive synchronised samples needed to accept a new level; legal range >= 2
CNT_W, 8, width of the rise, fall and glitch counters
WIDTH_W, 8, width of the pulse-width measurement

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_d  input  1  raw output of the delay module; asynchronous to i_clk
i_clr  input  1  synchronous clear of counters and width register
o_d_filt  output  1  filtered, synchronised level
o_rise  output  1  one-cycle pulse when o_d_filt goes 0->1
o_fall  output  1  one-cycle pulse when o_d_filt goes 1->0
o_rise_cnt  output  CNT_W  accepted rising edges, saturating
o_fall_cnt  output  CNT_W  accepted falling edges, saturating
o_glitch_cnt  output  CNT_W  rejected candidate transitions, saturating
o_pulse_width  output  WIDTH_W  length in cycles of the last accepted high pulse, saturating
o_width_valid  output  1  one-cycle pulse, coincident with o_fall

Behaviour:
- Reset (i_rst_n=0, asynchronous): both synchroniser flops = 0; FSM in IDLE_LO; all outputs and counters = 0.
- Synchroniser: two flip-flops in series; s = output of the second flop.
- FSM states and transitions:
  - IDLE_LO: if s=1, go to CAND_HI with stable counter = 1.
  - CAND_HI: if s=1 and counter = FILTER_LEN-1, go to IDLE_HI, set o_d_filt=1, pulse o_rise. If s=1 otherwise, increment counter. If s=0, increment glitch counter and return to IDLE_LO.
  - IDLE_HI and CAND_LO: mirror images of IDLE_LO and CAND_HI. Committing from CAND_LO pulses o_fall.
- Latency: i_d is first sampled at edge 1. If it stays at the new level, o_d_filt changes after edge FILTER_LEN+2, and o_rise/o_fall are high in the cycle after that edge.
- Pulse acceptance: a raw level held for L sampling edges is accepted if L >= FILTER_LEN. If L < FILTER_LEN, it counts as exactly one glitch and produces no o_d_filt change.
- Pulse width: the width counter clears on the rise commit and increments each cycle while in IDLE_HI or CAND_LO.
  - On the fall commit, o_pulse_width = cycles from the rise-commit edge to the fall-commit edge.
  - o_width_valid pulses together with o_fall.
  - The width counter saturates at 2^WIDTH_W-1.
- Counters: all saturate at 2^CNT_W-1 and never wrap.
- i_clr: zeroes all counters, o_pulse_width and the width accumulator. It does not affect the synchroniser, FSM or o_d_filt.
  - If i_clr coincides with an event, clear wins: the counter reads 0 after that edge.
  - o_rise/o_fall still pulse.
- Mid-operation reset: any state returns to IDLE_LO and every output goes to 0 immediately. A high i_d then needs FILTER_LEN+2 edges after release to be accepted.
- Outputs are registered; there are no combinational paths from i_d.

Decomposition:
- Package delay_mon_pkg holds:
  - typedef enum logic [1:0] mon_state_t {IDLE_LO, CAND_HI, IDLE_HI, CAND_LO};
  - default parameter constants;
  - a saturating-increment function.
- Sub-module sync_2ff (i_clk, i_rst_n, i_d, o_q) implements the synchroniser and is reused by other stages.

Test Plan:
All scenarios use FILTER_LEN=3 and CNT_W=WIDTH_W=8.
1. Reset state: assert i_rst_n=0 mid-simulation with i_d=1 -> all outputs read 0 immediately; after release, o_d_filt rises exactly 5 edges later.
2. Single accepted pulse: i_d=1 held 10 cycles, then 0 -> o_rise once, o_fall once; o_pulse_width=10 with o_width_valid; o_rise_cnt=1, o_fall_cnt=1, o_glitch_cnt=0.
3. Glitch rejection: i_d high for 1 cycle, then high for 2 cycles, separated by 5 low cycles -> o_d_filt stays 0, o_glitch_cnt=2, no o_rise.
4. Hazard on a high level: o_d_filt=1, then i_d drops to 0 for 2 cycles -> o_d_filt stays 1, o_glitch_cnt increments by 1, no o_fall.
5. Saturation: 300 accepted pulses -> o_rise_cnt=255 and o_fall_cnt=255; a high level held 400 cycles -> o_pulse_width=255.
6. Clear collision: i_clr asserted on the same edge as a rise commit -> o_rise pulses, o_rise_cnt=0 afterwards, o_d_filt=1.

Source files
------------

// File: rtl/delay_mon_pkg.sv
// Shared types, default sizes and helpers for the delay-output monitor stages.
package delay_mon_pkg;

  localparam int unsigned DEF_FILTER_LEN = 3;
  localparam int unsigned DEF_CNT_W      = 8;
  localparam int unsigned DEF_WIDTH_W    = 8;

  typedef enum logic [1:0] {IDLE_LO, CAND_HI, IDLE_HI, CAND_LO} mon_state_t;

  // Increment that sticks at the all-ones value of a 'width'-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the i_clk domain.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= 1'b0;
      o_q  <= 1'b0;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/delay_output_monitor.sv
// Synchronises and deglitches the delay module output, then reports clean
// edges, edge/glitch counts and the width of the last accepted high pulse.
module delay_output_monitor
  import delay_mon_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned WIDTH_W    = DEF_WIDTH_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_d,
  input  logic               i_clr,
  output logic               o_d_filt,
  output logic               o_rise,
  output logic               o_fall,
  output logic [CNT_W-1:0]   o_rise_cnt,
  output logic [CNT_W-1:0]   o_fall_cnt,
  output logic [CNT_W-1:0]   o_glitch_cnt,
  output logic [WIDTH_W-1:0] o_pulse_width,
  output logic               o_width_valid
);

  localparam int unsigned STB_W = $clog2(FILTER_LEN);

  logic               s;
  mon_state_t         state, next_state;
  logic [STB_W-1:0]   stb, next_stb;
  logic               rise_ev, fall_ev, glitch_ev;
  logic [WIDTH_W-1:0] width_acc;

  sync_2ff u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_d),
    .o_q     (s)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE_LO;
      stb   <= '0;
    end else begin
      state <= next_state;
      stb   <= next_stb;
    end
  end

  // A candidate level must be seen FILTER_LEN times in a row to commit.
  always_comb begin
    next_state = state;
    next_stb   = stb;
    rise_ev    = 1'b0;
    fall_ev    = 1'b0;
    glitch_ev  = 1'b0;
    case (state)
      IDLE_LO: if (s) begin
        next_state = CAND_HI;
        next_stb   = STB_W'(1);
      end
      CAND_HI: begin
        if (!s) begin
          glitch_ev  = 1'b1;
          next_state = IDLE_LO;
          next_stb   = '0;
        end else if (stb == STB_W'(FILTER_LEN - 1)) begin
          rise_ev    = 1'b1;
          next_state = IDLE_HI;
          next_stb   = '0;
        end else begin
          next_stb = stb + STB_W'(1);
        end
      end
      IDLE_HI: if (!s) begin
        next_state = CAND_LO;
        next_stb   = STB_W'(1);
      end
      CAND_LO: begin
        if (s) begin
          glitch_ev  = 1'b1;
          next_state = IDLE_HI;
          next_stb   = '0;
        end else if (stb == STB_W'(FILTER_LEN - 1)) begin
          fall_ev    = 1'b1;
          next_state = IDLE_LO;
          next_stb   = '0;
        end else begin
          next_stb = stb + STB_W'(1);
        end
      end
      default: begin
        next_state = IDLE_LO;
        next_stb   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_d_filt      <= 1'b0;
      o_rise        <= 1'b0;
      o_fall        <= 1'b0;
      o_width_valid <= 1'b0;
    end else begin
      o_d_filt      <= (next_state == IDLE_HI) || (next_state == CAND_LO);
      o_rise        <= rise_ev;
      o_fall        <= fall_ev;
      o_width_valid <= fall_ev;
    end
  end

  // Clear takes priority over any event landing on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rise_cnt   <= '0;
      o_fall_cnt   <= '0;
      o_glitch_cnt <= '0;
    end else if (i_clr) begin
      o_rise_cnt   <= '0;
      o_fall_cnt   <= '0;
      o_glitch_cnt <= '0;
    end else begin
      if (rise_ev)   o_rise_cnt   <= CNT_W'(sat_inc(32'(o_rise_cnt), CNT_W));
      if (fall_ev)   o_fall_cnt   <= CNT_W'(sat_inc(32'(o_fall_cnt), CNT_W));
      if (glitch_ev) o_glitch_cnt <= CNT_W'(sat_inc(32'(o_glitch_cnt), CNT_W));
    end
  end

  // The reported width includes the fall-commit edge itself.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      width_acc     <= '0;
      o_pulse_width <= '0;
    end else if (i_clr) begin
      width_acc     <= '0;
      o_pulse_width <= '0;
    end else begin
      if (rise_ev) begin
        width_acc <= '0;
      end else if ((state == IDLE_HI) || (state == CAND_LO)) begin
        width_acc <= WIDTH_W'(sat_inc(32'(width_acc), WIDTH_W));
      end
      if (fall_ev) begin
        o_pulse_width <= WIDTH_W'(sat_inc(32'(width_acc), WIDTH_W));
      end
    end
  end

endmodule
